// File: rtl/tug_referee_if.sv
// Button inputs and display outputs of the tug-of-war referee, bundled as one port.
// The master side owns the synchronized buttons; the slave side is the referee.
interface tug_referee_if #(
  parameter int NUM_LED = 9
) ();
  logic               sy_left;
  logic               sy_right;
  logic               sy_clear;
  logic [NUM_LED-1:0] led;
  logic               win_l;
  logic               win_r;
  logic               playing;
  logic [2:0]         state;

  modport master (
    output sy_left, sy_right, sy_clear,
    input  led, win_l, win_r, playing, state
  );

  modport slave (
    input  sy_left, sy_right, sy_clear,
    output led, win_l, win_r, playing, state
  );
endinterface

// File: rtl/tug_referee.sv
// Tug-of-war game controller: rising-edge detection on the synchronized buttons,
// IDLE/ARM/PLAY/WIN sequencing, rope position with post-move lockout, and
// registered one-hot LED bar plus winner flags.
module tug_referee #(
  parameter int NUM_LED  = 9,
  parameter int ARM_CYC  = 16,
  parameter int LOCK_CYC = 4,
  parameter int CNT_W    = 16
) (
  input  logic          clk,
  input  logic          rst,
  tug_referee_if.slave  bus
);

  localparam int POS_W  = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;
  localparam int CENTER = (NUM_LED - 1) / 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_WIN_L = 3'd3;
  localparam logic [2:0] S_WIN_R = 3'd4;

  localparam logic [POS_W-1:0] POS_CENTER = POS_W'(CENTER);
  localparam logic [POS_W-1:0] POS_ONE    = POS_W'(1);
  localparam logic [POS_W-1:0] POS_PRELST = POS_W'(NUM_LED - 2);
  localparam logic [CNT_W-1:0] ARM_LOAD   = CNT_W'(ARM_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD  = CNT_W'(LOCK_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // One-hot LED pattern for a rope position, bit 0 = left end.
  function automatic logic [NUM_LED-1:0] pos_to_led(input logic [POS_W-1:0] p);
    pos_to_led = {{(NUM_LED-1){1'b0}}, 1'b1} << p;
  endfunction

  logic [2:0]         state_q, state_n;
  logic [POS_W-1:0]   pos_q, pos_n;
  logic [CNT_W-1:0]   arm_q, arm_n;
  logic [CNT_W-1:0]   lock_q, lock_n;
  logic               prev_l, prev_r, prev_c;
  logic [NUM_LED-1:0] led_q;
  logic               win_l_q, win_r_q, playing_q;
  logic               ev_l, ev_r, ev_c;

  assign ev_l = bus.sy_left  & ~prev_l;
  assign ev_r = bus.sy_right & ~prev_r;
  assign ev_c = bus.sy_clear & ~prev_c;

  // Next-state, rope position and counter decisions; clear always wins.
  always_comb begin
    state_n = state_q;
    pos_n   = pos_q;
    arm_n   = arm_q;
    lock_n  = lock_q;
    case (state_q)
      S_IDLE: begin
        if (ev_c) begin
          state_n = S_ARM;
          arm_n   = ARM_LOAD;
          lock_n  = '0;
        end
      end
      S_ARM: begin
        if (ev_c) begin
          state_n = S_IDLE;
          pos_n   = POS_CENTER;
          arm_n   = '0;
        end else if (ev_l && ev_r) begin
          state_n = S_IDLE;
          arm_n   = '0;
        end else if (ev_l) begin
          state_n = S_WIN_R;
          arm_n   = '0;
        end else if (ev_r) begin
          state_n = S_WIN_L;
          arm_n   = '0;
        end else if (arm_q == '0) begin
          state_n = S_PLAY;
        end else begin
          arm_n = arm_q - CNT_ONE;
        end
      end
      S_PLAY: begin
        if (ev_c) begin
          state_n = S_IDLE;
          pos_n   = POS_CENTER;
          lock_n  = '0;
        end else if (lock_q != '0) begin
          lock_n = lock_q - CNT_ONE;
        end else if (ev_l && !ev_r && pos_q != '0) begin
          pos_n  = pos_q - POS_ONE;
          lock_n = LOCK_LOAD;
          if (pos_q == POS_ONE) state_n = S_WIN_L;
        end else if (ev_r && !ev_l && pos_q != POS_W'(NUM_LED - 1)) begin
          pos_n  = pos_q + POS_ONE;
          lock_n = LOCK_LOAD;
          if (pos_q == POS_PRELST) state_n = S_WIN_R;
        end
      end
      S_WIN_L, S_WIN_R: begin
        if (ev_c) begin
          state_n = S_IDLE;
          pos_n   = POS_CENTER;
          lock_n  = '0;
        end
      end
      default: begin
        state_n = S_IDLE;
        pos_n   = POS_CENTER;
        arm_n   = '0;
        lock_n  = '0;
      end
    endcase
  end

  // Game state, edge history and registered display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pos_q     <= POS_CENTER;
      arm_q     <= '0;
      lock_q    <= '0;
      prev_l    <= 1'b0;
      prev_r    <= 1'b0;
      prev_c    <= 1'b0;
      led_q     <= pos_to_led(POS_CENTER);
      win_l_q   <= 1'b0;
      win_r_q   <= 1'b0;
      playing_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      pos_q     <= pos_n;
      arm_q     <= arm_n;
      lock_q    <= lock_n;
      prev_l    <= bus.sy_left;
      prev_r    <= bus.sy_right;
      prev_c    <= bus.sy_clear;
      led_q     <= pos_to_led(pos_n);
      win_l_q   <= (state_n == S_WIN_L);
      win_r_q   <= (state_n == S_WIN_R);
      playing_q <= (state_n == S_PLAY);
    end
  end

  assign bus.led     = led_q;
  assign bus.win_l   = win_l_q;
  assign bus.win_r   = win_r_q;
  assign bus.playing = playing_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_tug_referee.sv
// Scenario bench for tug_referee: expected display snapshots are queued as
// stimulus is driven and compared once the clock edge has produced output.
module tb_tug_referee;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ARM   = 3'd1;
  localparam logic [2:0] PLAY  = 3'd2;
  localparam logic [2:0] WIN_L = 3'd3;
  localparam logic [2:0] WIN_R = 3'd4;

  typedef logic [14:0] snap_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    checks = 0;
  int    failures = 0;
  snap_t exp_q[$];
  snap_t got, want;

  tug_referee_if #(.NUM_LED(9)) bus ();

  tug_referee #(.NUM_LED(9), .ARM_CYC(16), .LOCK_CYC(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic snap_t mk(input int p, input logic wl, input logic wr,
                               input logic pl, input logic [2:0] st);
    logic [8:0] l;
    l = 9'b1 << p;
    return {l, wl, wr, pl, st};
  endfunction

  function automatic snap_t snap();
    return {bus.led, bus.win_l, bus.win_r, bus.playing, bus.state};
  endfunction

  // Drive buttons on the falling edge, then let one rising edge act on them.
  task automatic tick(input logic l, input logic r, input logic c);
    @(negedge clk);
    bus.sy_left  = l;
    bus.sy_right = r;
    bus.sy_clear = c;
    @(posedge clk);
    #1;
  endtask

  task automatic start_play();
    tick(0, 0, 1);
    repeat (16) tick(0, 0, 0);
  endtask

  task automatic test_reset();
    bus.sy_left = 1'b1; bus.sy_right = 1'b1; bus.sy_clear = 1'b0;
    rst = 1'b1;
    exp_q.push_back(mk(4, 0, 0, 0, IDLE));
    repeat (2) @(posedge clk);
    #1;
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL reset_held got=%h want=%h", got, want); end
    @(negedge clk); rst = 1'b0;
    exp_q.push_back(mk(4, 0, 0, 0, IDLE));
    tick(1, 1, 0); tick(1, 1, 0);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL reset_release got=%h want=%h", got, want); end
    tick(0, 0, 0);
  endtask

  task automatic test_arm_and_left_win();
    exp_q.push_back(mk(4, 0, 0, 0, ARM));
    tick(0, 0, 1);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL arm_entry got=%h want=%h", got, want); end
    exp_q.push_back(mk(4, 0, 0, 0, ARM));
    repeat (15) tick(0, 0, 0);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL arm_16th got=%h want=%h", got, want); end
    exp_q.push_back(mk(4, 0, 0, 1, PLAY));
    tick(0, 0, 0);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL play_17th got=%h want=%h", got, want); end
    for (int n = 0; n < 4; n++) begin
      if (n < 3) exp_q.push_back(mk(3 - n, 0, 0, 1, PLAY));
      else       exp_q.push_back(mk(0, 1, 0, 0, WIN_L));
      tick(1, 0, 0);
      got = snap(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL left_step%0d got=%h want=%h", n, got, want); end
      repeat (5) tick(0, 0, 0);
    end
    exp_q.push_back(mk(0, 1, 0, 0, WIN_L));
    tick(0, 1, 0);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL winl_frozen got=%h want=%h", got, want); end
    exp_q.push_back(mk(4, 0, 0, 0, IDLE));
    tick(0, 0, 1);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL winl_clear got=%h want=%h", got, want); end
    tick(0, 0, 0);
  endtask

  task automatic test_hold_and_tie();
    start_play();
    exp_q.push_back(mk(5, 0, 0, 1, PLAY));
    tick(0, 1, 0);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL hold_first got=%h want=%h", got, want); end
    exp_q.push_back(mk(5, 0, 0, 1, PLAY));
    repeat (19) tick(0, 1, 0);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL hold_20 got=%h want=%h", got, want); end
    tick(0, 0, 0);
    exp_q.push_back(mk(4, 0, 0, 1, PLAY));
    tick(1, 0, 0);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL back_left got=%h want=%h", got, want); end
    repeat (5) tick(0, 0, 0);
    exp_q.push_back(mk(4, 0, 0, 1, PLAY));
    tick(1, 1, 0);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL tie got=%h want=%h", got, want); end
    tick(0, 0, 0);
    exp_q.push_back(mk(5, 0, 0, 1, PLAY));
    tick(0, 1, 0);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL tie_nolock got=%h want=%h", got, want); end
    tick(0, 0, 1);
    tick(0, 0, 0);
  endtask

  task automatic test_lockout_and_right_win();
    start_play();
    exp_q.push_back(mk(5, 0, 0, 1, PLAY));
    tick(0, 1, 0);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL lock_move got=%h want=%h", got, want); end
    tick(0, 0, 0);
    exp_q.push_back(mk(5, 0, 0, 1, PLAY));
    tick(1, 0, 0);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL lock_discard got=%h want=%h", got, want); end
    tick(0, 0, 0); tick(0, 0, 0);
    exp_q.push_back(mk(4, 0, 0, 1, PLAY));
    tick(1, 0, 0);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL lock_expired got=%h want=%h", got, want); end
    repeat (5) tick(0, 0, 0);
    for (int n = 0; n < 4; n++) begin
      if (n < 3) exp_q.push_back(mk(5 + n, 0, 0, 1, PLAY));
      else       exp_q.push_back(mk(8, 0, 1, 0, WIN_R));
      tick(0, 1, 0);
      got = snap(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin failures++; $display("FAIL right_step%0d got=%h want=%h", n, got, want); end
      repeat (5) tick(0, 0, 0);
    end
    exp_q.push_back(mk(8, 0, 1, 0, WIN_R));
    tick(1, 0, 0);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL winr_frozen got=%h want=%h", got, want); end
    tick(0, 0, 1);
    tick(0, 0, 0);
  endtask

  task automatic test_false_start();
    tick(0, 0, 1); tick(0, 0, 0); tick(0, 0, 0);
    exp_q.push_back(mk(4, 0, 1, 0, WIN_R));
    tick(1, 0, 0);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL false_left got=%h want=%h", got, want); end
    tick(0, 0, 0);
    exp_q.push_back(mk(4, 0, 0, 0, IDLE));
    tick(0, 0, 1);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL winr_clear got=%h want=%h", got, want); end
    tick(0, 0, 0);
    tick(0, 0, 1); tick(0, 0, 0);
    exp_q.push_back(mk(4, 1, 0, 0, WIN_L));
    tick(0, 1, 0);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL false_right got=%h want=%h", got, want); end
    tick(0, 0, 1); tick(0, 0, 0);
    tick(0, 0, 1); tick(0, 0, 0);
    exp_q.push_back(mk(4, 0, 0, 0, IDLE));
    tick(1, 1, 0);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL double_foul got=%h want=%h", got, want); end
    tick(0, 0, 0);
    tick(0, 0, 1); tick(0, 0, 0);
    exp_q.push_back(mk(4, 0, 0, 0, IDLE));
    tick(0, 0, 1);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL arm_clear got=%h want=%h", got, want); end
    tick(0, 0, 0);
  endtask

  task automatic test_clear_and_async_reset();
    start_play();
    exp_q.push_back(mk(3, 0, 0, 1, PLAY));
    tick(1, 0, 0);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL pre_clear got=%h want=%h", got, want); end
    repeat (5) tick(0, 0, 0);
    exp_q.push_back(mk(4, 0, 0, 0, IDLE));
    tick(0, 1, 1);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL clear_beats_right got=%h want=%h", got, want); end
    tick(0, 0, 0);
    start_play();
    tick(0, 1, 0);
    tick(0, 0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    exp_q.push_back(mk(4, 0, 0, 0, IDLE));
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL async_rst got=%h want=%h", got, want); end
    @(negedge clk); rst = 1'b0;
    exp_q.push_back(mk(4, 0, 0, 0, IDLE));
    tick(0, 0, 0);
    got = snap(); want = exp_q.pop_front(); checks++;
    if (got !== want) begin failures++; $display("FAIL post_rst got=%h want=%h", got, want); end
  endtask

  initial begin
    bus.sy_left = 1'b0; bus.sy_right = 1'b0; bus.sy_clear = 1'b0;
    test_reset();
    test_arm_and_left_win();
    test_hold_and_tie();
    test_lockout_and_right_win();
    test_false_start();
    test_clear_and_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
